branch_predictor: RTL and testbench
===================================

# branch_predictor

Fetch-stage branch predictor: the producer side of the branch-resolution interface whose consumer is the EX-stage ALU. Each cycle it looks up the fetch PC in a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, and drives the predicted direction and target into the pipeline, where they are flopped forward as the EX prediction. It is trained from the EX resolution: true direction, mispredict flag and corrected PC.

## Interface
Parameters:
- XLEN, 32, datapath width of EX_alu_out.
- PC_BITS, 12, instruction-address width. The PC increments by 1 per instruction.
- BTB_ENTRIES, 16, BTB depth. Must be a power of two, at least 2 and at most 2^(PC_BITS-1).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- IF_pc  in  PC_BITS  fetch PC being looked up.
- IF_BP_taken  out  1  predicted taken.
- IF_BP_target_pc  out  PC_BITS  predicted next PC.
- EX_valid  in  1  EX stage holds a real instruction, not a bubble.
- EX_pc  in  PC_BITS  PC of the instruction in EX.
- EX_brn  in  1  the EX instruction is a branch or jump.
- EX_true_taken  in  1  resolved direction.
- EX_taken  in  1  mispredict, meaning a flush is issued this cycle.
- EX_alu_out  in  XLEN  resolved next PC; only the low PC_BITS bits are used.

## Operation
- IDX = $clog2(BTB_ENTRIES). Index = pc[IDX-1:0]. Tag = pc[PC_BITS-1:IDX].
- Each entry holds: valid, tag, target[PC_BITS-1:0], and cnt[1:0]. Counter encoding: 00 = strong not-taken, 01 = weak not-taken, 10 = weak taken, 11 = strong taken.
- Lookup (combinational):
  - hit = valid && (tag == IF_pc tag).
  - IF_BP_taken = hit && cnt[1].
  - IF_BP_target_pc = IF_BP_taken ? target : IF_pc + 1, computed modulo 2^PC_BITS, so the all-ones PC wraps to 0.
- Update happens only when EX_valid && EX_brn. The EX lookup uses EX_pc.
  - Taken and hit: cnt increments, saturating at 11; target is overwritten with EX_alu_out[PC_BITS-1:0], so stale register-based targets self-correct.
  - Taken and miss (invalid entry or tag mismatch): allocate or replace the entry with valid = 1, the new tag and target, and cnt = 10.
  - Not taken and hit: cnt decrements, saturating at 00; target and valid are unchanged.
  - Not taken and miss: no change. Not-taken branches are never allocated.
- When EX_valid = 0 or EX_brn = 0, no state changes. EX_taken has no effect on the table.

## Timing
- Lookup has zero-cycle latency: outputs are purely combinational from IF_pc and table state.
- An update is written at the rising edge where the EX conditions hold, and is visible to lookups from the next cycle.
- If IF and EX address the same index in the same cycle, the lookup returns the pre-update contents; there is no bypass.
- Reset, asserted asynchronously at any time including mid-update:
  - every entry goes to valid = 0, tag = 0, target = 0, cnt = 01, immediately and without a clock;
  - outputs immediately become IF_BP_taken = 0 and IF_BP_target_pc = IF_pc + 1;
  - a pending update is discarded.
- Release of rst_n is synchronous to clk. The first update can be taken at the first edge after release.

## Configuration
- BP_STATS_EN defined:
  - adds outputs bp_branch_cnt (out, 32) and bp_mispredict_cnt (out, 32);
  - bp_branch_cnt increments on each EX_valid && EX_brn edge;
  - bp_mispredict_cnt increments when EX_taken is also 1;
  - both saturate at 2^32-1 and reset to 0.
- BP_STATS_EN undefined: these ports and their counters do not exist, and all other behaviour is identical.

## Structure
- Shared package bp_pkg holds:
  - counter encodings (BP_SNT = 00, BP_WNT = 01, BP_WT = 10, BP_ST = 11);
  - saturating increment and decrement functions;
  - the BP_CNT_RESET constant (= BP_WNT).
- One sub-module, bp_btb: the entry array with the async-reset storage, a combinational read port (IF index) and a write port (EX index, write enable, entry data). branch_predictor holds the hit/allocate logic, counter update, next-PC mux and the optional statistics.

## Test plan
- Cold after reset, IF_pc = 0x010: IF_BP_taken = 0 and IF_BP_target_pc = 0x011. IF_pc = 0xFFF gives target 0x000.
- EX resolves branch EX_pc = 0x010 taken to 0x040: next cycle IF_pc = 0x010 gives taken = 1, target 0x040, cnt = 10. A second taken resolution gives cnt = 11.
- With cnt = 11, two not-taken resolutions at 0x010 give cnt = 01 and prediction not-taken, target 0x011. Two more keep cnt at 00 and valid stays 1.
- Aliasing with BTB_ENTRIES = 16: taken at 0x010, then taken at 0x110 to 0x080. A lookup of 0x010 now misses (not-taken) and 0x110 predicts 0x080. A not-taken resolution at 0x210 changes nothing.
- Same-cycle conflict: IF_pc = EX_pc = 0x020 on an initial allocation: that cycle predicts not-taken, the next cycle predicts taken. EX_valid = 0 with EX_brn = 1 leaves the table unchanged.
- Assert rst_n low mid-cycle while an update is pending: outputs become not-taken and PC+1 without waiting for a clock edge, all entries miss afterwards, and with BP_STATS_EN both counters read 0.

Source files
------------

// File: rtl/bp_pkg.sv
// bp_pkg
//   Shared definitions for the fetch-stage branch predictor: 2-bit
//   saturating counter encodings, the counter reset value and the
//   saturating increment/decrement helpers used by the update logic.
package bp_pkg;

  typedef logic [1:0] bp_cnt_t;

  localparam bp_cnt_t BP_SNT = 2'b00;  // strong not-taken
  localparam bp_cnt_t BP_WNT = 2'b01;  // weak not-taken
  localparam bp_cnt_t BP_WT  = 2'b10;  // weak taken
  localparam bp_cnt_t BP_ST  = 2'b11;  // strong taken

  localparam bp_cnt_t BP_CNT_RESET = BP_WNT;

  function automatic bp_cnt_t bp_sat_inc(input bp_cnt_t c);
    return (c == BP_ST) ? BP_ST : bp_cnt_t'(c + 2'd1);
  endfunction

  function automatic bp_cnt_t bp_sat_dec(input bp_cnt_t c);
    return (c == BP_SNT) ? BP_SNT : bp_cnt_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// branch_predictor_if
//   Groups the fetch lookup and EX resolution signals of the branch
//   predictor.
//   Fetch side : IF_pc (to predictor), IF_BP_taken / IF_BP_target_pc (from it)
//   EX side    : EX_valid, EX_pc, EX_brn, EX_true_taken, EX_taken, EX_alu_out
//   Modports   : master = pipeline driving the predictor, slave = predictor.
interface branch_predictor_if #(
  parameter int XLEN    = 32,
  parameter int PC_BITS = 12
);

  logic [PC_BITS-1:0] IF_pc;
  logic               IF_BP_taken;
  logic [PC_BITS-1:0] IF_BP_target_pc;

  logic               EX_valid;
  logic [PC_BITS-1:0] EX_pc;
  logic               EX_brn;
  logic               EX_true_taken;
  logic               EX_taken;
  logic [XLEN-1:0]    EX_alu_out;

  modport master (
    output IF_pc, EX_valid, EX_pc, EX_brn, EX_true_taken, EX_taken, EX_alu_out,
    input  IF_BP_taken, IF_BP_target_pc
  );

  modport slave (
    input  IF_pc, EX_valid, EX_pc, EX_brn, EX_true_taken, EX_taken, EX_alu_out,
    output IF_BP_taken, IF_BP_target_pc
  );

endinterface

// File: rtl/bp_btb.sv
// bp_btb
//   Direct-mapped branch target buffer storage with asynchronous reset.
//   Ports:
//     clk, rst_n          clock, async active-low reset (clears every entry)
//     rd_idx  / rd_*      combinational read port for the fetch lookup
//     ex_idx  / ex_*      combinational read of the EX entry, also the write index
//     wr_en   / wr_*      entry data written at ex_idx on the rising edge
module bp_btb
  import bp_pkg::*;
#(
  parameter int PC_BITS = 12,
  parameter int ENTRIES = 16,
  localparam int IDX    = $clog2(ENTRIES),
  localparam int TAG_W  = PC_BITS - IDX
) (
  input  logic               clk,
  input  logic               rst_n,

  input  logic [IDX-1:0]     rd_idx,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [PC_BITS-1:0] rd_target,
  output bp_cnt_t            rd_cnt,

  input  logic [IDX-1:0]     ex_idx,
  output logic               ex_valid,
  output logic [TAG_W-1:0]   ex_tag,
  output logic [PC_BITS-1:0] ex_target,
  output bp_cnt_t            ex_cnt,

  input  logic               wr_en,
  input  logic               wr_valid,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [PC_BITS-1:0] wr_target,
  input  bp_cnt_t            wr_cnt
);

  logic [ENTRIES-1:0]              valid_q, valid_d;
  logic [ENTRIES-1:0][TAG_W-1:0]   tag_q, tag_d;
  logic [ENTRIES-1:0][PC_BITS-1:0] target_q, target_d;
  bp_cnt_t [ENTRIES-1:0]           cnt_q, cnt_d;

  // Reads see the registered contents only, so a same-cycle write to
  // the fetch index is not bypassed to the lookup.
  assign rd_valid  = valid_q[rd_idx];
  assign rd_tag    = tag_q[rd_idx];
  assign rd_target = target_q[rd_idx];
  assign rd_cnt    = cnt_q[rd_idx];

  assign ex_valid  = valid_q[ex_idx];
  assign ex_tag    = tag_q[ex_idx];
  assign ex_target = target_q[ex_idx];
  assign ex_cnt    = cnt_q[ex_idx];

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (wr_en) begin
      valid_d[ex_idx]  = wr_valid;
      tag_d[ex_idx]    = wr_tag;
      target_d[ex_idx] = wr_target;
      cnt_d[ex_idx]    = wr_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      tag_q    <= '0;
      target_q <= '0;
      cnt_q    <= {ENTRIES{BP_CNT_RESET}};
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor
//   Fetch-stage branch predictor: direct-mapped BTB with 2-bit saturating
//   counters, looked up combinationally with IF_pc and trained from the
//   EX-stage resolution.
//   Ports:
//     clk, rst_n   clock, async active-low reset
//     bp           branch_predictor_if.slave (fetch lookup + EX resolution)
//     bp_branch_cnt, bp_mispredict_cnt   saturating 32-bit statistics,
//                  present only when BP_STATS_EN is defined
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int PC_BITS     = 12,
  parameter int BTB_ENTRIES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  branch_predictor_if.slave bp
`ifdef BP_STATS_EN
  ,
  output logic [31:0]       bp_branch_cnt,
  output logic [31:0]       bp_mispredict_cnt
`endif
);

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = PC_BITS - IDX;

  logic               if_valid, ex_valid;
  logic [TAG_W-1:0]   if_tag_rd, ex_tag_rd;
  logic [PC_BITS-1:0] if_target, ex_target;
  bp_cnt_t            if_cnt, ex_cnt;

  logic               wr_en, wr_valid;
  logic [TAG_W-1:0]   wr_tag;
  logic [PC_BITS-1:0] wr_target;
  bp_cnt_t            wr_cnt;

  logic               if_hit, ex_hit, upd;

  bp_btb #(
    .PC_BITS (PC_BITS),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (bp.IF_pc[IDX-1:0]),
    .rd_valid  (if_valid),
    .rd_tag    (if_tag_rd),
    .rd_target (if_target),
    .rd_cnt    (if_cnt),
    .ex_idx    (bp.EX_pc[IDX-1:0]),
    .ex_valid  (ex_valid),
    .ex_tag    (ex_tag_rd),
    .ex_target (ex_target),
    .ex_cnt    (ex_cnt),
    .wr_en     (wr_en),
    .wr_valid  (wr_valid),
    .wr_tag    (wr_tag),
    .wr_target (wr_target),
    .wr_cnt    (wr_cnt)
  );

  assign if_hit = if_valid && (if_tag_rd == bp.IF_pc[PC_BITS-1:IDX]);
  assign ex_hit = ex_valid && (ex_tag_rd == bp.EX_pc[PC_BITS-1:IDX]);
  assign upd    = bp.EX_valid && bp.EX_brn;

  // Fall-through wraps modulo 2^PC_BITS.
  assign bp.IF_BP_taken     = if_hit && if_cnt[1];
  assign bp.IF_BP_target_pc = bp.IF_BP_taken ? if_target
                                             : bp.IF_pc + PC_BITS'(1);

  // Taken branches always (re)write the entry so a stale target from a
  // register-indirect jump is corrected; not-taken only trains a hit.
  always_comb begin
    wr_en     = 1'b0;
    wr_valid  = ex_valid;
    wr_tag    = ex_tag_rd;
    wr_target = ex_target;
    wr_cnt    = ex_cnt;
    if (upd) begin
      if (bp.EX_true_taken) begin
        wr_en     = 1'b1;
        wr_valid  = 1'b1;
        wr_tag    = bp.EX_pc[PC_BITS-1:IDX];
        wr_target = bp.EX_alu_out[PC_BITS-1:0];
        wr_cnt    = ex_hit ? bp_sat_inc(ex_cnt) : BP_WT;
      end else if (ex_hit) begin
        wr_en  = 1'b1;
        wr_cnt = bp_sat_dec(ex_cnt);
      end
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] br_cnt_q, br_cnt_d, mp_cnt_q, mp_cnt_d;
  logic        unused_alu_hi;

  assign unused_alu_hi = ^bp.EX_alu_out[XLEN-1:PC_BITS];

  always_comb begin
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (upd && (br_cnt_q != '1))
      br_cnt_d = br_cnt_q + 32'd1;
    if (upd && bp.EX_taken && (mp_cnt_q != '1))
      mp_cnt_d = mp_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign bp_branch_cnt     = br_cnt_q;
  assign bp_mispredict_cnt = mp_cnt_q;
`else
  // The mispredict flag only feeds the statistics.
  logic unused_bits;
  assign unused_bits = ^{bp.EX_alu_out[XLEN-1:PC_BITS], bp.EX_taken};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor
//   Directed-vector scoreboard bench for branch_predictor (XLEN 32,
//   PC_BITS 12, 16 BTB entries). Optional statistics outputs are checked
//   when BP_STATS_EN is defined.
module tb_branch_predictor;

  logic clk;
  logic rst_n;

  branch_predictor_if #(.XLEN(32), .PC_BITS(12)) bpif();

`ifdef BP_STATS_EN
  logic [31:0] bp_branch_cnt, bp_mispredict_cnt;
`endif

  branch_predictor #(
    .XLEN        (32),
    .PC_BITS     (12),
    .BTB_ENTRIES (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bpif)
`ifdef BP_STATS_EN
    ,
    .bp_branch_cnt     (bp_branch_cnt),
    .bp_mispredict_cnt (bp_mispredict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        taken;
    logic [11:0] tgt;
    logic [31:0] br;
    logic [31:0] mp;
  } exp_t;

  exp_t        exp_q[$];
  logic        lookup_valid;
  int          n_vectors;
  int          n_miscompares;
  logic [31:0] br_model, mp_model;

  // Compare one presented lookup against its queued expectation.
  task automatic checkOutput(input exp_t e);
    n_vectors++;
    if (bpif.IF_BP_taken !== e.taken) begin
      n_miscompares++;
      $display("[TB] FAIL taken pc=%03h got=%0b exp=%0b", bpif.IF_pc, bpif.IF_BP_taken, e.taken);
    end
    n_vectors++;
    if (bpif.IF_BP_target_pc !== e.tgt) begin
      n_miscompares++;
      $display("[TB] FAIL target pc=%03h got=%03h exp=%03h", bpif.IF_pc, bpif.IF_BP_target_pc, e.tgt);
    end
`ifdef BP_STATS_EN
    n_vectors++;
    if (bp_branch_cnt !== e.br) begin
      n_miscompares++;
      $display("[TB] FAIL branch_cnt got=%0d exp=%0d", bp_branch_cnt, e.br);
    end
    n_vectors++;
    if (bp_mispredict_cnt !== e.mp) begin
      n_miscompares++;
      $display("[TB] FAIL mispredict_cnt got=%0d exp=%0d", bp_mispredict_cnt, e.mp);
    end
`endif
  endtask

  // Drive one cycle of fetch + EX inputs after the rising edge and queue
  // the expected lookup seen at the following falling edge. mid_rst pulls
  // rst_n low between the drive and the sample, with the update pending.
  task automatic applyStimulus(
    input logic        rst_v,
    input logic        mid_rst,
    input logic [11:0] if_pc,
    input logic        exv,
    input logic [11:0] ex_pc,
    input logic        brn,
    input logic        tt,
    input logic        tk,
    input logic [31:0] alu,
    input logic        et,
    input logic [11:0] etgt
  );
    exp_t e;
    @(posedge clk);
    #1;
    rst_n               = rst_v;
    bpif.IF_pc          = if_pc;
    bpif.EX_valid       = exv;
    bpif.EX_pc          = ex_pc;
    bpif.EX_brn         = brn;
    bpif.EX_true_taken  = tt;
    bpif.EX_taken       = tk;
    bpif.EX_alu_out     = alu;
    if (!rst_v || mid_rst) begin
      br_model = '0;
      mp_model = '0;
    end
    e.taken = et;
    e.tgt   = etgt;
    e.br    = br_model;
    e.mp    = mp_model;
    exp_q.push_back(e);
    lookup_valid = 1'b1;
    if (rst_v && !mid_rst && exv && brn) begin
      br_model = br_model + 32'd1;
      if (tk) mp_model = mp_model + 32'd1;
    end
    if (mid_rst) begin
      #2;
      rst_n = 1'b0;
    end
  endtask

  // Monitor: pops one expectation per presented lookup.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (lookup_valid) begin
        if (exp_q.size() == 0) begin
          n_vectors++;
          n_miscompares++;
          $display("[TB] FAIL scoreboard_empty got=lookup exp=none");
        end else begin
          e = exp_q.pop_front();
          checkOutput(e);
        end
      end
    end
  end

  initial begin
    n_vectors     = 0;
    n_miscompares = 0;
    br_model      = '0;
    mp_model      = '0;
    lookup_valid  = 1'b0;
    rst_n         = 1'b0;
    bpif.IF_pc         = '0;
    bpif.EX_valid      = 1'b0;
    bpif.EX_pc         = '0;
    bpif.EX_brn        = 1'b0;
    bpif.EX_true_taken = 1'b0;
    bpif.EX_taken      = 1'b0;
    bpif.EX_alu_out    = '0;

    //            rst  mid  IF_pc   exv ex_pc   brn tt tk alu            et  etgt
    // cold lookups
    applyStimulus(0, 0, 12'h010, 0, 12'h000, 0, 0, 0, 32'h0,          0, 12'h011);
    applyStimulus(1, 0, 12'hFFF, 0, 12'h000, 0, 0, 0, 32'h0,          0, 12'h000);
    // allocate 0x010 -> 0x040 (upper alu bits ignored); same-cycle lookup sees old state
    applyStimulus(1, 0, 12'h010, 1, 12'h010, 1, 1, 1, 32'hABCD_0040,  0, 12'h011);
    applyStimulus(1, 0, 12'h010, 1, 12'h010, 1, 1, 0, 32'h0000_0040,  1, 12'h040);
    // counter 11 -> 10 -> 01 -> 00 -> 00
    applyStimulus(1, 0, 12'h010, 1, 12'h010, 1, 0, 1, 32'h0,          1, 12'h040);
    applyStimulus(1, 0, 12'h010, 1, 12'h010, 1, 0, 0, 32'h0,          1, 12'h040);
    applyStimulus(1, 0, 12'h010, 1, 12'h010, 1, 0, 0, 32'h0,          0, 12'h011);
    applyStimulus(1, 0, 12'h010, 1, 12'h010, 1, 0, 0, 32'h0,          0, 12'h011);
    // 00 + taken hit -> 01 (still valid), then 10 with new target
    applyStimulus(1, 0, 12'h010, 1, 12'h010, 1, 1, 1, 32'h0000_0050,  0, 12'h011);
    applyStimulus(1, 0, 12'h010, 1, 12'h010, 1, 1, 1, 32'h0000_0060,  0, 12'h011);
    applyStimulus(1, 0, 12'h010, 0, 12'h000, 0, 0, 0, 32'h0,          1, 12'h060);
    // aliasing: 0x110 replaces 0x010; not-taken miss at 0x210 is ignored
    applyStimulus(1, 0, 12'h110, 1, 12'h110, 1, 1, 1, 32'h0000_0080,  0, 12'h111);
    applyStimulus(1, 0, 12'h010, 1, 12'h210, 1, 0, 0, 32'h0,          0, 12'h011);
    applyStimulus(1, 0, 12'h110, 0, 12'h000, 0, 0, 0, 32'h0,          1, 12'h080);
    // same-cycle conflict at 0x020, then gated updates
    applyStimulus(1, 0, 12'h020, 1, 12'h020, 1, 1, 1, 32'h0000_0030,  0, 12'h021);
    applyStimulus(1, 0, 12'h020, 0, 12'h020, 1, 0, 1, 32'h0,          1, 12'h030);
    applyStimulus(1, 0, 12'h020, 1, 12'h020, 0, 0, 0, 32'h0,          1, 12'h030);
    applyStimulus(1, 0, 12'h020, 0, 12'h000, 0, 0, 0, 32'h0,          1, 12'h030);
    applyStimulus(1, 0, 12'h030, 1, 12'h030, 0, 1, 1, 32'h0000_0099,  0, 12'h031);
    applyStimulus(1, 0, 12'h030, 0, 12'h000, 0, 0, 0, 32'h0,          0, 12'h031);
    // async reset mid-cycle with an update to 0x020 pending
    applyStimulus(1, 1, 12'h110, 1, 12'h020, 1, 1, 1, 32'h0000_0070,  0, 12'h111);
    applyStimulus(0, 0, 12'h020, 1, 12'h020, 1, 1, 1, 32'h0000_0070,  0, 12'h021);
    applyStimulus(1, 0, 12'h020, 0, 12'h000, 0, 0, 0, 32'h0,          0, 12'h021);
    applyStimulus(1, 0, 12'h010, 0, 12'h000, 0, 0, 0, 32'h0,          0, 12'h011);
    applyStimulus(1, 0, 12'h110, 0, 12'h000, 0, 0, 0, 32'h0,          0, 12'h111);
    // first update after release
    applyStimulus(1, 0, 12'h020, 1, 12'h020, 1, 1, 0, 32'h0000_0044,  0, 12'h021);
    applyStimulus(1, 0, 12'h020, 0, 12'h000, 0, 0, 0, 32'h0,          1, 12'h044);

    @(posedge clk);
    #1;
    lookup_valid = 1'b0;
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_vectors++;
      n_miscompares++;
      $display("[TB] FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
